// File: rtl/mux_select_decoder.sv
// Mux select decoder: turns a (row, col) request into one-hot switch enables with
// break-before-make dead time and settle delay. Optional feature macro: MUX_SKIP_SAME_ADDR_EN.
module mux_select_decoder #(
   parameter int unsigned Width        = 5,
   parameter int unsigned Rows         = 2,
   parameter int unsigned Cols         = 2,
   parameter int unsigned DeadCycles   = 4,
   parameter int unsigned SettleCycles = 50
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [Width-1:0] row_i,
   input  logic [Width-1:0] col_i,
   input  logic             req_i,
   input  logic             release_i,
   output logic [Rows-1:0]  row_sel_o,
   output logic [Cols-1:0]  col_sel_o,
   output logic             busy_o,
   output logic             ready_o,
   output logic             err_o
);

   localparam logic [15:0] DeadLoad   = 16'(DeadCycles - 1);
   localparam logic [15:0] SettleLoad = 16'(SettleCycles - 1);

   typedef enum logic [1:0] {
      StIdle,
      StBreak,
      StSettle,
      StReady
   } state_e;

   state_e           state_q, state_d;
   logic [15:0]      cnt_q, cnt_d;
   logic [Width-1:0] row_q, row_d;
   logic [Width-1:0] col_q, col_d;

   logic [Rows-1:0]  row_hit;
   logic [Cols-1:0]  col_hit;
   logic [Rows-1:0]  row_sel_d;
   logic [Cols-1:0]  col_sel_d;
   logic             busy_d;
   logic             ready_d;
   logic             err_d;
   logic             in_range;

   // Range check at full address width so wide addresses never alias into the matrix.
   assign in_range = (32'(row_i) < Rows) && (32'(col_i) < Cols);

`ifdef MUX_SKIP_SAME_ADDR_EN
   logic same_addr;
   assign same_addr = (row_i == row_q) && (col_i == col_q);
`endif

   // State and registered outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         row_q     <= '0;
         col_q     <= '0;
         row_sel_o <= '0;
         col_sel_o <= '0;
         busy_o    <= 1'b0;
         ready_o   <= 1'b0;
         err_o     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         row_q     <= row_d;
         col_q     <= col_d;
         row_sel_o <= row_sel_d;
         col_sel_o <= col_sel_d;
         busy_o    <= busy_d;
         ready_o   <= ready_d;
         err_o     <= err_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      row_d   = row_q;
      col_d   = col_q;
      err_d   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (req_i) begin
               if (in_range) begin
                  state_d = StBreak;
                  cnt_d   = DeadLoad;
                  row_d   = row_i;
                  col_d   = col_i;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         StBreak: begin
            if (cnt_q == '0) begin
               state_d = StSettle;
               cnt_d   = SettleLoad;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         StSettle: begin
            if (cnt_q == '0) begin
               state_d = StReady;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         StReady: begin
            // A request takes priority over a simultaneous release.
            if (req_i) begin
               if (in_range) begin
`ifdef MUX_SKIP_SAME_ADDR_EN
                  if (!same_addr) begin
                     state_d = StBreak;
                     cnt_d   = DeadLoad;
                     row_d   = row_i;
                     col_d   = col_i;
                  end
`else
                  state_d = StBreak;
                  cnt_d   = DeadLoad;
                  row_d   = row_i;
                  col_d   = col_i;
`endif
               end else begin
                  err_d = 1'b1;
               end
            end else if (release_i) begin
               state_d = StIdle;
            end
         end
      endcase
   end

   for (genvar g = 0; g < Rows; g++) begin : g_row_hit
      assign row_hit[g] = (32'(row_d) == 32'(g));
   end

   for (genvar g = 0; g < Cols; g++) begin : g_col_hit
      assign col_hit[g] = (32'(col_d) == 32'(g));
   end

   // Outputs are decoded from the next state so they register alongside it.
   always_comb begin
      row_sel_d = '0;
      col_sel_d = '0;
      busy_d    = (state_d == StBreak) || (state_d == StSettle);
      ready_d   = (state_d == StReady);
      if ((state_d == StSettle) || (state_d == StReady)) begin
         row_sel_d = row_hit;
         col_sel_d = col_hit;
      end
   end

   a_row_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(row_sel_o));
   a_col_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(col_sel_o));
   a_open_when_idle: assert property (@(posedge clk_i) disable iff (!rst_ni)
      ((state_q == StIdle) || (state_q == StBreak)) |-> ((row_sel_o == '0) && (col_sel_o == '0)));

endmodule

// File: tb/tb_mux_select_decoder.sv
// Directed testbench for mux_select_decoder (default parameters); honours MUX_SKIP_SAME_ADDR_EN.
module tb_mux_select_decoder;

   logic       clk_i = 1'b0;
   logic       rst_ni;
   logic [4:0] row_i;
   logic [4:0] col_i;
   logic       req_i;
   logic       release_i;
   logic [1:0] row_sel_o;
   logic [1:0] col_sel_o;
   logic       busy_o;
   logic       ready_o;
   logic       err_o;
   logic [6:0] obs;
   logic [6:0] exp_v;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk_i = ~clk_i;

   // {row_sel, col_sel, busy, ready, err}
   assign obs = {row_sel_o, col_sel_o, busy_o, ready_o, err_o};

   mux_select_decoder #(
      .Width        (5),
      .Rows         (2),
      .Cols         (2),
      .DeadCycles   (4),
      .SettleCycles (50)
   ) dut (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .row_i     (row_i),
      .col_i     (col_i),
      .req_i     (req_i),
      .release_i (release_i),
      .row_sel_o (row_sel_o),
      .col_sel_o (col_sel_o),
      .busy_o    (busy_o),
      .ready_o   (ready_o),
      .err_o     (err_o)
   );

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic tick_n(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic drive(input logic [4:0] r, input logic [4:0] c, input logic rq, input logic rl);
      row_i     = r;
      col_i     = c;
      req_i     = rq;
      release_i = rl;
   endtask

   task automatic do_req(input logic [4:0] r, input logic [4:0] c);
      drive(r, c, 1'b1, 1'b0);
      tick();
      drive(5'd0, 5'd0, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      rst_ni = 1'b0;
      drive(5'd0, 5'd0, 1'b0, 1'b0);
      repeat (2) @(posedge clk_i);
      #1;
      n_tests++;
      if (obs !== 7'b00_00_0_0_0) begin
         n_fail++;
         $display("FAIL reset_hold got %b want %b", obs, 7'b0);
      end
      rst_ni = 1'b1;
      tick();
      n_tests++;
      if (obs !== 7'b00_00_0_0_0) begin
         n_fail++;
         $display("FAIL reset_release got %b want %b", obs, 7'b0);
      end
   endtask

   task automatic test_basic();
      do_req(5'd1, 5'd0);
      n_tests++;
      if (obs !== 7'b00_00_1_0_0) begin
         n_fail++;
         $display("FAIL basic k=0 got %b want %b", obs, 7'b00_00_1_0_0);
      end
      for (int k = 1; k <= 56; k++) begin
         tick();
         exp_v = {(k >= 4) ? 4'b10_01 : 4'b00_00, (k <= 53), (k >= 54), 1'b0};
         n_tests++;
         if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL basic k=%0d got %b want %b", k, obs, exp_v);
         end
      end
   endtask

   task automatic test_readdress();
      do_req(5'd0, 5'd1);
      n_tests++;
      if (obs !== 7'b00_00_1_0_0) begin
         n_fail++;
         $display("FAIL readdr k=0 got %b want %b", obs, 7'b00_00_1_0_0);
      end
      for (int k = 1; k <= 54; k++) begin
         tick();
         exp_v = {(k >= 4) ? 4'b01_10 : 4'b00_00, (k <= 53), (k >= 54), 1'b0};
         n_tests++;
         if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL readdr k=%0d got %b want %b", k, obs, exp_v);
         end
      end
   endtask

   task automatic test_err();
      do_req(5'd2, 5'd0);
      n_tests++;
      if (obs !== 7'b01_10_0_1_1) begin
         n_fail++;
         $display("FAIL err_ready_row got %b want %b", obs, 7'b01_10_0_1_1);
      end
      tick();
      n_tests++;
      if (obs !== 7'b01_10_0_1_0) begin
         n_fail++;
         $display("FAIL err_ready_pulse got %b want %b", obs, 7'b01_10_0_1_0);
      end
      do_req(5'd0, 5'd2);
      n_tests++;
      if (obs !== 7'b01_10_0_1_1) begin
         n_fail++;
         $display("FAIL err_ready_col got %b want %b", obs, 7'b01_10_0_1_1);
      end
      drive(5'd0, 5'd0, 1'b0, 1'b1);
      tick();
      drive(5'd0, 5'd0, 1'b0, 1'b0);
      n_tests++;
      if (obs !== 7'b00_00_0_0_0) begin
         n_fail++;
         $display("FAIL release got %b want %b", obs, 7'b0);
      end
      do_req(5'd2, 5'd0);
      n_tests++;
      if (obs !== 7'b00_00_0_0_1) begin
         n_fail++;
         $display("FAIL err_idle got %b want %b", obs, 7'b00_00_0_0_1);
      end
      tick();
      n_tests++;
      if (obs !== 7'b00_00_0_0_0) begin
         n_fail++;
         $display("FAIL err_idle_pulse got %b want %b", obs, 7'b0);
      end
      do_req(5'd31, 5'd31);
      n_tests++;
      if (obs !== 7'b00_00_0_0_1) begin
         n_fail++;
         $display("FAIL err_idle_max got %b want %b", obs, 7'b00_00_0_0_1);
      end
      tick();
      n_tests++;
      if (obs !== 7'b00_00_0_0_0) begin
         n_fail++;
         $display("FAIL err_idle_stay got %b want %b", obs, 7'b0);
      end
   endtask

   // Requests (valid, out-of-range, with release) while busy must not perturb timing.
   task automatic test_ignore_busy();
      do_req(5'd1, 5'd1);
      for (int k = 1; k <= 54; k++) begin
         if (k == 2) drive(5'd0, 5'd0, 1'b1, 1'b1);
         else if (k == 10) drive(5'd0, 5'd1, 1'b1, 1'b1);
         else if (k == 20) drive(5'd3, 5'd0, 1'b1, 1'b0);
         else if (k == 53) drive(5'd0, 5'd0, 1'b1, 1'b0);
         else drive(5'd0, 5'd0, 1'b0, 1'b0);
         tick();
         exp_v = {(k >= 4) ? 4'b10_10 : 4'b00_00, (k <= 53), (k >= 54), 1'b0};
         n_tests++;
         if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL ignore_busy k=%0d got %b want %b", k, obs, exp_v);
         end
      end
      drive(5'd0, 5'd0, 1'b0, 1'b0);
   endtask

   task automatic test_req_release();
      drive(5'd0, 5'd0, 1'b1, 1'b1);
      tick();
      drive(5'd0, 5'd0, 1'b0, 1'b0);
      n_tests++;
      if (obs !== 7'b00_00_1_0_0) begin
         n_fail++;
         $display("FAIL req_rel k=0 got %b want %b", obs, 7'b00_00_1_0_0);
      end
      tick_n(3);
      n_tests++;
      if (obs !== 7'b00_00_1_0_0) begin
         n_fail++;
         $display("FAIL req_rel k=3 got %b want %b", obs, 7'b00_00_1_0_0);
      end
      tick();
      n_tests++;
      if (obs !== 7'b01_01_1_0_0) begin
         n_fail++;
         $display("FAIL req_rel k=4 got %b want %b", obs, 7'b01_01_1_0_0);
      end
      tick_n(49);
      n_tests++;
      if (obs !== 7'b01_01_1_0_0) begin
         n_fail++;
         $display("FAIL req_rel k=53 got %b want %b", obs, 7'b01_01_1_0_0);
      end
      tick();
      n_tests++;
      if (obs !== 7'b01_01_0_1_0) begin
         n_fail++;
         $display("FAIL req_rel k=54 got %b want %b", obs, 7'b01_01_0_1_0);
      end
      drive(5'd0, 5'd0, 1'b0, 1'b1);
      tick();
      drive(5'd0, 5'd0, 1'b0, 1'b0);
      n_tests++;
      if (obs !== 7'b00_00_0_0_0) begin
         n_fail++;
         $display("FAIL release_only got %b want %b", obs, 7'b0);
      end
      tick();
      n_tests++;
      if (obs !== 7'b00_00_0_0_0) begin
         n_fail++;
         $display("FAIL release_stay got %b want %b", obs, 7'b0);
      end
   endtask

   task automatic test_same_addr();
      do_req(5'd1, 5'd0);
      tick_n(54);
      n_tests++;
      if (obs !== 7'b10_01_0_1_0) begin
         n_fail++;
         $display("FAIL same_setup got %b want %b", obs, 7'b10_01_0_1_0);
      end
      do_req(5'd1, 5'd0);
`ifdef MUX_SKIP_SAME_ADDR_EN
      n_tests++;
      if (obs !== 7'b10_01_0_1_0) begin
         n_fail++;
         $display("FAIL same_skip k=0 got %b want %b", obs, 7'b10_01_0_1_0);
      end
      tick_n(60);
      n_tests++;
      if (obs !== 7'b10_01_0_1_0) begin
         n_fail++;
         $display("FAIL same_skip k=60 got %b want %b", obs, 7'b10_01_0_1_0);
      end
`else
      n_tests++;
      if (obs !== 7'b00_00_1_0_0) begin
         n_fail++;
         $display("FAIL same_reseq k=0 got %b want %b", obs, 7'b00_00_1_0_0);
      end
      tick_n(3);
      n_tests++;
      if (obs !== 7'b00_00_1_0_0) begin
         n_fail++;
         $display("FAIL same_reseq k=3 got %b want %b", obs, 7'b00_00_1_0_0);
      end
      tick();
      n_tests++;
      if (obs !== 7'b10_01_1_0_0) begin
         n_fail++;
         $display("FAIL same_reseq k=4 got %b want %b", obs, 7'b10_01_1_0_0);
      end
      tick_n(50);
      n_tests++;
      if (obs !== 7'b10_01_0_1_0) begin
         n_fail++;
         $display("FAIL same_reseq k=54 got %b want %b", obs, 7'b10_01_0_1_0);
      end
`endif
   endtask

   task automatic test_async_reset();
      drive(5'd0, 5'd0, 1'b0, 1'b1);
      tick();
      drive(5'd0, 5'd0, 1'b0, 1'b0);
      do_req(5'd0, 5'd0);
      tick_n(10);
      n_tests++;
      if (obs !== 7'b01_01_1_0_0) begin
         n_fail++;
         $display("FAIL arst_settle got %b want %b", obs, 7'b01_01_1_0_0);
      end
      #3;
      rst_ni = 1'b0;
      #1;
      n_tests++;
      if (obs !== 7'b00_00_0_0_0) begin
         n_fail++;
         $display("FAIL arst_async got %b want %b", obs, 7'b0);
      end
      tick();
      rst_ni = 1'b1;
      tick();
      n_tests++;
      if (obs !== 7'b00_00_0_0_0) begin
         n_fail++;
         $display("FAIL arst_idle got %b want %b", obs, 7'b0);
      end
      do_req(5'd1, 5'd1);
      tick_n(3);
      n_tests++;
      if (obs !== 7'b00_00_1_0_0) begin
         n_fail++;
         $display("FAIL arst_restart k=3 got %b want %b", obs, 7'b00_00_1_0_0);
      end
      tick();
      n_tests++;
      if (obs !== 7'b10_10_1_0_0) begin
         n_fail++;
         $display("FAIL arst_restart k=4 got %b want %b", obs, 7'b10_10_1_0_0);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_readdress();
      test_err();
      test_ignore_busy();
      test_req_release();
      test_same_addr();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
